// File: rtl/toggle_req_rx.sv
// Receive side of the toggle request/acknowledge link: synchronizes req_tgl, captures
// req_data on each serviced flip, presents it on valid/ready and flips ack_tgl once accepted.
module toggle_req_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] req_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              ack_tgl,
   output logic [CNT_W-1:0]  evt_count,
   output logic              overrun,
   input  logic              clr_overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_PRESENT,
      S_ACK
   } state_e;

   state_e                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    req_seen_q, req_seen_d;
   logic                    valid_q, valid_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic                    ack_q, ack_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovr_q, ovr_d;
   logic                    ovr_set;
   logic                    sync_out;
   logic                    pending;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign pending  = sync_out ^ req_seen_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_seen_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_seen_q <= req_seen_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
      end
   end

   // Any flip seen while a transfer is in flight is a protocol violation; a single
   // extra flip stays pending and is serviced once the FSM is back in IDLE.
   always_comb begin
      state_d    = state_q;
      req_seen_d = req_seen_q;
      valid_d    = valid_q;
      data_d     = data_q;
      ack_d      = ack_q;
      cnt_d      = cnt_q;
      ovr_set    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pending) begin
               req_seen_d = sync_out;
               state_d    = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            ovr_set = pending;
            data_d  = req_data;
            valid_d = 1'b1;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            ovr_set = pending;
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            ovr_set = pending;
            ack_d   = ~ack_q;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ovr_d = ovr_set | (ovr_q & ~clr_overrun);
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign ack_tgl   = ack_q;
   assign evt_count = cnt_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_toggle_req_rx.sv
// Bench for toggle_req_rx: SYNC_STAGES=2 and SYNC_STAGES=3 instances share one sender and
// are checked every cycle against a timestamp-based transfer model, plus literal checks.
module tb_toggle_req_rx;

   logic       clk;
   logic       rst_n;
   logic       req_tgl;
   logic [7:0] req_data;
   logic       out_ready;
   logic       clr_overrun;

   logic       v0, v1, a0, a1, o0, o1;
   logic [7:0] d0, d1, c0, c1;

   int unsigned checks;
   int unsigned failures;
   logic        rand_mode;

   toggle_req_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
      .out_valid(v0), .out_data(d0), .out_ready(out_ready), .ack_tgl(a0),
      .evt_count(c0), .overrun(o0), .clr_overrun(clr_overrun));

   toggle_req_rx #(.DATA_W(8), .SYNC_STAGES(3), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
      .out_valid(v1), .out_data(d1), .out_ready(out_ready), .ack_tgl(a1),
      .evt_count(c1), .overrun(o1), .clr_overrun(clr_overrun));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: the request level seen at edge k is the req_tgl sampled at edge k-S;
   // a detected flip captures one edge later, waits for ready, then acks one edge after that.
   localparam int unsigned SOF [2] = '{2, 3};
   logic [15:0] hist;
   int unsigned k_m;
   logic        m_seen [2];
   logic        m_busy [2];
   logic        m_acc  [2];
   int unsigned m_cap  [2];
   logic        m_valid[2];
   logic [7:0]  m_data [2];
   logic        m_ack  [2];
   int unsigned m_cnt  [2];
   logic        m_ovr  [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_m  = 0;
         hist = '0;
         for (int i = 0; i < 2; i++) begin
            m_seen[i] = 0; m_busy[i] = 0; m_acc[i] = 0; m_cap[i] = 0;
            m_valid[i] = 0; m_data[i] = '0; m_ack[i] = 0; m_cnt[i] = 0; m_ovr[i] = 0;
         end
      end else begin
         k_m++;
         for (int i = 0; i < 2; i++) begin
            automatic logic view = (k_m > SOF[i]) ? hist[4'((k_m - SOF[i]) % 16)] : 1'b0;
            automatic logic pend = (view != m_seen[i]);
            automatic logic set  = 1'b0;
            if (!m_busy[i]) begin
               if (pend) begin
                  m_seen[i] = view;
                  m_busy[i] = 1;
                  m_cap[i]  = k_m + 1;
                  m_acc[i]  = 0;
               end
            end else begin
               set = pend;
               if (k_m == m_cap[i]) begin
                  m_data[i]  = req_data;
                  m_valid[i] = 1;
               end else if (!m_acc[i]) begin
                  if (out_ready) begin
                     m_valid[i] = 0;
                     m_acc[i]   = 1;
                  end
               end else begin
                  m_ack[i]  = ~m_ack[i];
                  m_cnt[i]  = (m_cnt[i] + 1) % 256;
                  m_busy[i] = 0;
               end
            end
            if (set) m_ovr[i] = 1;
            else if (clr_overrun) m_ovr[i] = 0;
         end
         hist[4'(k_m % 16)] = req_tgl;
      end
   end

   task automatic cmp(input int i, input logic v, input logic [7:0] d, input logic a,
                      input logic [7:0] c, input logic o);
      chk($sformatf("u%0d.out_valid", i), 32'(v), 32'(m_valid[i]));
      chk($sformatf("u%0d.out_data", i),  32'(d), 32'(m_data[i]));
      chk($sformatf("u%0d.ack_tgl", i),   32'(a), 32'(m_ack[i]));
      chk($sformatf("u%0d.evt_count", i), 32'(c), m_cnt[i]);
      chk($sformatf("u%0d.overrun", i),   32'(o), 32'(m_ovr[i]));
   endtask

   always @(negedge clk) begin
      cmp(0, v0, d0, a0, c0, o0);
      cmp(1, v1, d1, a1, c1, o1);
   end

   task automatic drive_rand();
      if (rand_mode) begin
         out_ready   = ($urandom_range(0, 1) == 1);
         clr_overrun = ($urandom_range(0, 15) == 0);
      end
   endtask

   task automatic send(input logic [7:0] d);
      req_data = d;
      req_tgl  = ~req_tgl;
   endtask

   task automatic wait_ack(input int n, input string nm);
      logic last;
      int   got;
      last = a0;
      got  = 0;
      for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
         @(negedge clk);
         drive_rand();
         if (a0 !== last) begin
            got++;
            last = a0;
         end
      end
      chk({nm, ".acks"}, 32'(got), 32'(n));
   endtask

   task automatic wait_valid(input string nm);
      logic seen;
      seen = 1'b0;
      for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
         @(negedge clk);
         drive_rand();
         if (v0) seen = 1'b1;
      end
      chk({nm, ".valid_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req_tgl     = 1'b0;
      out_ready   = 1'b0;
      clr_overrun = 1'b0;
      rand_mode   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0; rand_mode = 1'b0;
      req_tgl = 1'b0; req_data = '0; out_ready = 1'b0; clr_overrun = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst.valid", 32'(v0), 32'd0);
      chk("rst.data", 32'(d0), 32'd0);
      chk("rst.ack", 32'(a0), 32'd0);
      chk("rst.cnt", 32'(c0), 32'd0);
      chk("rst.ovr", 32'(o0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single transfer with ready held high; latency S+2 to valid
      req_data = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("s1.u0.valid.e%0d", e), 32'(v0), (e == 4) ? 32'd1 : 32'd0);
         chk($sformatf("s1.u1.valid.e%0d", e), 32'(v1), (e == 5) ? 32'd1 : 32'd0);
         chk($sformatf("s1.u0.ack.e%0d", e), 32'(a0), (e >= 6) ? 32'd1 : 32'd0);
         chk($sformatf("s1.u1.ack.e%0d", e), 32'(a1), (e >= 7) ? 32'd1 : 32'd0);
         if (e == 4) chk("s1.u0.data", 32'(d0), 32'hA5);
         if (e == 5) chk("s1.u1.data", 32'(d1), 32'hA5);
         if (e == 6) chk("s1.u0.cnt", 32'(c0), 32'd1);
      end
      chk("s1.model.cnt", m_cnt[0], 32'd1);
      chk("s1.model.ack", 32'(m_ack[0]), 32'd1);

      // Three transfers, second stalled for five cycles
      do_reset();
      out_ready = 1'b1;
      send(8'h01); wait_ack(1, "s2.t1");
      out_ready = 1'b0;
      send(8'h02); wait_valid("s2.t2");
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk($sformatf("s2.stall.valid%0d", s), 32'(v0), 32'd1);
         chk($sformatf("s2.stall.data%0d", s), 32'(d0), 32'h02);
      end
      out_ready = 1'b1;
      wait_ack(1, "s2.t2");
      send(8'h03); wait_ack(1, "s2.t3");
      chk("s2.ack", 32'(a0), 32'd1);
      chk("s2.cnt", 32'(c0), 32'd3);
      chk("s2.ovr", 32'(o0), 32'd0);

      // Overrun: extra flip during PRESENT, clear, then set-wins-over-clear
      do_reset();
      send(8'h11); wait_valid("s3.a");
      send(8'h22);
      repeat (5) @(negedge clk);
      chk("s3.ovr_set", 32'(o0), 32'd1);
      out_ready = 1'b1;
      wait_ack(1, "s3.a");
      wait_valid("s3.b");
      chk("s3.second_data", 32'(d0), 32'h22);
      wait_ack(1, "s3.b");
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("s3.ovr_clr", 32'(o0), 32'd0);
      out_ready = 1'b0;
      send(8'h33); wait_valid("s3.c");
      clr_overrun = 1'b1;
      send(8'h44);
      repeat (6) @(negedge clk);
      chk("s3.set_wins", 32'(o0), 32'd1);
      clr_overrun = 1'b0;
      out_ready = 1'b1;
      wait_ack(2, "s3.cd");
      chk("s3.cnt", 32'(c0), 32'd4);

      // Asynchronous reset while PRESENT
      do_reset();
      out_ready = 1'b1;
      send(8'h77); wait_ack(1, "s4.pre");
      out_ready = 1'b0;
      send(8'h5A); wait_valid("s4");
      #2 rst_n = 1'b0;
      #1;
      chk("s4.valid", 32'(v0), 32'd0);
      chk("s4.data", 32'(d0), 32'd0);
      chk("s4.ack", 32'(a0), 32'd0);
      chk("s4.cnt", 32'(c0), 32'd0);
      chk("s4.u1.data", 32'(d1), 32'd0);
      req_tgl = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("s4.noack", 32'(a0), 32'd0);
      chk("s4.cnt_after", 32'(c0), 32'd0);

      // Counter wrap after 256 transfers
      do_reset();
      out_ready = 1'b1;
      for (int t = 0; t < 256; t++) begin
         send(8'(t));
         wait_ack(1, "s5");
         if (t == 254) chk("s5.cnt255", 32'(c0), 32'd255);
      end
      chk("s5.cnt_wrap", 32'(c0), 32'd0);
      chk("s5.ack", 32'(a0), 32'd0);

      // Randomized traffic with occasional single extra flips
      do_reset();
      rand_mode = 1'b1;
      for (int t = 0; t < 200; t++) begin
         automatic int n = 1;
         send(8'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            wait_valid("s6");
            send(8'($urandom));
            n = 2;
         end
         wait_ack(n, "s6");
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            drive_rand();
         end
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      clr_overrun = 1'b0;
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
